// File: rtl/rib_arbiter_pkg.sv
// Shared constants for the tinyriscv bus arbiter: master/slave counts, slave-select
// address field and the starvation counter width.
package rib_defs;

    localparam int RIB_MASTERS = 4;
    localparam int RIB_SLAVES  = 6;
    localparam int RIB_SEL_MSB = 31;
    localparam int RIB_SEL_LSB = 28;

    localparam int M_EX   = 0;
    localparam int M_PC   = 1;
    localparam int M_JTAG = 2;
    localparam int M_UART = 3;

    localparam int WAIT_CNT_W = 4;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/rib_arbiter_prio_pick.sv
// Combinational winner picker: a starved requester (lowest index first) beats the
// fixed m0 > m1 > m2 > m3 order.
module rib_prio_pick
    import rib_defs::*;
(
    input  logic [RIB_MASTERS-1:0] req,
    input  logic [RIB_MASTERS-1:1] starved,
    output logic [RIB_MASTERS-1:0] grant,
    output logic                   valid
);

    logic [RIB_MASTERS-1:1] starved_req;

    assign starved_req = starved & req[RIB_MASTERS-1:1];
    assign valid       = |req;

    always_comb begin
        grant = '0;
        if (starved_req[M_PC]) begin
            grant[M_PC] = 1'b1;
        end else if (starved_req[M_JTAG]) begin
            grant[M_JTAG] = 1'b1;
        end else if (starved_req[M_UART]) begin
            grant[M_UART] = 1'b1;
        end else if (req[M_EX]) begin
            grant[M_EX] = 1'b1;
        end else if (req[M_PC]) begin
            grant[M_PC] = 1'b1;
        end else if (req[M_JTAG]) begin
            grant[M_JTAG] = 1'b1;
        end else if (req[M_UART]) begin
            grant[M_UART] = 1'b1;
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Four-master to six-slave single-cycle bus arbiter with address decode, starvation
// promotion for m1..m3, core stall request and a registered decode-error pulse.
module rib_arbiter
    import rib_defs::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RIB_MASTERS-1:0]        m_req_i,
    input  logic [RIB_MASTERS-1:0]        m_we_i,
    input  logic [RIB_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [RIB_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [RIB_MASTERS*DATA_W-1:0] m_rdata_o,
    output logic [RIB_SLAVES-1:0]         s_sel_o,
    output logic [RIB_SLAVES-1:0]         s_we_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic [RIB_SLAVES*DATA_W-1:0]  s_rdata_i,
    output logic                          hold_flag_o,
    output logic                          dec_err_o
);

    localparam wait_cnt_t LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

    logic [RIB_MASTERS-1:1][WAIT_CNT_W-1:0] wait_cnt;
    logic [RIB_MASTERS-1:1]                 starved;
    logic [RIB_MASTERS-1:0]                 grant;
    logic                                   valid;
    logic [ADDR_W-1:0]                      win_addr;
    logic [DATA_W-1:0]                      win_wdata;
    logic                                   win_we;
    logic [RIB_SEL_MSB-RIB_SEL_LSB:0]       slv_idx;
    logic                                   mapped;
    logic [DATA_W-1:0]                      sel_rdata;
    logic                                   dec_err_q;

    always_comb begin
        for (int k = 1; k < RIB_MASTERS; k++) begin
            starved[k] = (wait_cnt[k] == LIMIT);
        end
    end

    rib_prio_pick u_pick (
        .req     (m_req_i),
        .starved (starved),
        .grant   (grant),
        .valid   (valid)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        for (int k = 0; k < RIB_MASTERS; k++) begin
            if (grant[k]) begin
                win_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
                win_wdata = m_wdata_i[k*DATA_W +: DATA_W];
                win_we    = m_we_i[k];
            end
        end
    end

    assign slv_idx = win_addr[RIB_SEL_MSB:RIB_SEL_LSB];
    assign mapped  = (slv_idx < 4'(RIB_SLAVES));

    // Everything downstream is gated by reset so an in-flight access is dropped at once.
    always_comb begin
        s_sel_o     = '0;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        m_rdata_o   = '0;
        hold_flag_o = 1'b0;
        sel_rdata   = '0;
        if (rst && valid) begin
            s_addr_o    = {{(ADDR_W-RIB_SEL_LSB){1'b0}}, win_addr[RIB_SEL_LSB-1:0]};
            s_wdata_o   = win_wdata;
            hold_flag_o = !grant[M_PC];
            for (int s = 0; s < RIB_SLAVES; s++) begin
                if (mapped && (slv_idx == 4'(s))) begin
                    s_sel_o[s] = 1'b1;
                    s_we_o[s]  = win_we;
                    sel_rdata  = s_rdata_i[s*DATA_W +: DATA_W];
                end
            end
            for (int k = 0; k < RIB_MASTERS; k++) begin
                if (grant[k]) begin
                    m_rdata_o[k*DATA_W +: DATA_W] = sel_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            dec_err_q <= 1'b0;
        end else begin
            for (int k = 1; k < RIB_MASTERS; k++) begin
                if (!m_req_i[k] || grant[k]) begin
                    wait_cnt[k] <= '0;
                end else if (wait_cnt[k] != LIMIT) begin
                    wait_cnt[k] <= wait_cnt[k] + 1'b1;
                end
            end
            dec_err_q <= valid && !mapped;
        end
    end

    assign dec_err_o = dec_err_q;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: reset, priority, starvation, write routing,
// unmapped decode and asynchronous reset mid-stream.
module tb_rib_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   m_req_i;
    logic [3:0]   m_we_i;
    logic [127:0] m_addr_i;
    logic [127:0] m_wdata_i;
    logic [127:0] m_rdata_o;
    logic [5:0]   s_sel_o;
    logic [5:0]   s_we_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [191:0] s_rdata_i;
    logic         hold_flag_o;
    logic         dec_err_o;

    int checks = 0;
    int errors = 0;

    rib_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_rdata_o   (m_rdata_o),
        .s_sel_o     (s_sel_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rdata_i   (s_rdata_i),
        .hold_flag_o (hold_flag_o),
        .dec_err_o   (dec_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int k, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        m_we_i[k]             = we;
        m_addr_i[k*32 +: 32]  = addr;
        m_wdata_i[k*32 +: 32] = wdata;
    endtask

    initial begin
        rst       = 1'b0;
        m_req_i   = 4'hF;
        m_we_i    = 4'h0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        for (int s = 0; s < 6; s++) s_rdata_i[s*32 +: 32] = 32'hA000_0000 + 32'(s);
        set_master(0, 1'b1, 32'h1000_0020, 32'hCAFE_0000);
        set_master(1, 1'b0, 32'h0000_0010, 32'h0);
        set_master(2, 1'b0, 32'h2000_0000, 32'h0);
        set_master(3, 1'b0, 32'h2000_0000, 32'h0);

        // Reset held with every master requesting
        #2;
        check("rst_sel",   128'(s_sel_o), 128'h0);
        check("rst_we",    128'(s_we_o), 128'h0);
        check("rst_addr",  128'(s_addr_o), 128'h0);
        check("rst_wdata", 128'(s_wdata_o), 128'h0);
        check("rst_rdata", m_rdata_o, 128'h0);
        check("rst_hold",  128'(hold_flag_o), 128'h0);
        check("rst_derr",  128'(dec_err_o), 128'h0);

        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rel_sel",  128'(s_sel_o), 128'h02);
        check("rel_we",   128'(s_we_o), 128'h02);
        check("rel_hold", 128'(hold_flag_o), 128'h1);
        check("rel_rd0",  128'(m_rdata_o[31:0]), 128'hA000_0001);
        check("rel_addr", 128'(s_addr_o), 128'h0000_0020);

        next_cycle();
        m_req_i = 4'h0;
        @(negedge clk);
        check("idle_sel",  128'(s_sel_o), 128'h0);
        check("idle_hold", 128'(hold_flag_o), 128'h0);
        check("idle_rd",   m_rdata_o, 128'h0);

        // Priority read: m1 over m2
        next_cycle();
        s_rdata_i[31:0] = 32'hDEAD_BEEF;
        m_req_i = 4'b0110;
        @(negedge clk);
        check("pri_sel",  128'(s_sel_o), 128'h01);
        check("pri_rd1",  128'(m_rdata_o[63:32]), 128'hDEAD_BEEF);
        check("pri_rd2",  128'(m_rdata_o[95:64]), 128'h0);
        check("pri_hold", 128'(hold_flag_o), 128'h0);
        check("pri_addr", 128'(s_addr_o), 128'h10);

        // Write routing from m0
        next_cycle();
        m_req_i = 4'b0001;
        set_master(0, 1'b1, 32'h3000_0004, 32'h1234_5678);
        @(negedge clk);
        check("wr_sel",   128'(s_sel_o), 128'h08);
        check("wr_we",    128'(s_we_o), 128'h08);
        check("wr_addr",  128'(s_addr_o), 128'h4);
        check("wr_wdata", 128'(s_wdata_o), 128'h1234_5678);
        check("wr_hold",  128'(hold_flag_o), 128'h1);

        // Unmapped read from m2 and its one-cycle error pulse
        next_cycle();
        m_req_i = 4'b0100;
        set_master(2, 1'b0, 32'h7000_0000, 32'h0);
        @(negedge clk);
        check("um_sel",  128'(s_sel_o), 128'h0);
        check("um_we",   128'(s_we_o), 128'h0);
        check("um_rd2",  128'(m_rdata_o[95:64]), 128'h0);
        check("um_hold", 128'(hold_flag_o), 128'h1);
        check("um_derr0", 128'(dec_err_o), 128'h0);
        next_cycle();
        m_req_i = 4'b0000;
        @(negedge clk);
        check("um_derr1", 128'(dec_err_o), 128'h1);
        next_cycle();
        @(negedge clk);
        check("um_derr2", 128'(dec_err_o), 128'h0);

        // Starvation: m1 and m3 compete, m3 promoted every ninth cycle
        next_cycle();
        m_req_i = 4'b1010;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 9 || c == 18) begin
                check($sformatf("stv_m3_sel_c%0d", c), 128'(s_sel_o), 128'h04);
                check($sformatf("stv_m3_hold_c%0d", c), 128'(hold_flag_o), 128'h1);
                check($sformatf("stv_m3_rd_c%0d", c), 128'(m_rdata_o[127:96]), 128'hA000_0002);
            end else begin
                check($sformatf("stv_m1_sel_c%0d", c), 128'(s_sel_o), 128'h01);
                check($sformatf("stv_m1_hold_c%0d", c), 128'(hold_flag_o), 128'h0);
            end
            next_cycle();
        end

        // Starved m1 beats m0
        m_req_i = 4'b0000;
        @(negedge clk);
        next_cycle();
        m_req_i = 4'b0011;
        set_master(0, 1'b0, 32'h3000_0004, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("m1stv_hold_c%0d", c), 128'(hold_flag_o), (c == 9) ? 128'h0 : 128'h1);
            next_cycle();
        end

        // Async reset while m3 has waited 5 cycles behind an m0 write
        m_req_i = 4'b0000;
        @(negedge clk);
        next_cycle();
        m_req_i = 4'b1001;
        set_master(0, 1'b1, 32'h3000_0004, 32'h5555_AAAA);
        for (int c = 0; c < 5; c++) next_cycle();
        check("ar_cnt_pre", 128'(dut.wait_cnt[3]), 128'h5);
        check("ar_we_pre",  128'(s_we_o), 128'h08);
        #2;
        rst = 1'b0;
        #1;
        check("ar_cnt",  128'(dut.wait_cnt[3]), 128'h0);
        check("ar_we",   128'(s_we_o), 128'h0);
        check("ar_sel",  128'(s_sel_o), 128'h0);
        check("ar_hold", 128'(hold_flag_o), 128'h0);
        next_cycle();
        rst = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("ar_restart_sel_c%0d", c), 128'(s_sel_o), (c == 9) ? 128'h04 : 128'h08);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Bus arbiter and address decoder sitting directly downstream of the `tinyriscv` core's bus ports. It merges four masters onto one shared slave bus:
- m0 = core data/ex port
- m1 = core instruction fetch port
- m2 = JTAG debug
- m3 = UART debug loader

It picks one master per cycle by fixed priority with starvation promotion, routes the access to one of six slaves by address, and stalls the core through `hold_flag_o`. Transfers complete in a single cycle, combinationally; arbitration history lives in registers.

## Interface
Parameters:
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `STARVE_LIMIT`, 8: wait cycles before a master is promoted; legal range 1..15

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, asynchronous, active-low
- `m_req_i`  in  4  per-master request
- `m_we_i`  in  4  per-master write enable
- `m_addr_i`  in  4*ADDR_W  per-master address, master k at bits [k*ADDR_W +: ADDR_W]
- `m_wdata_i`  in  4*DATA_W  per-master write data
- `m_rdata_o`  out  4*DATA_W  per-master read data
- `s_sel_o`  out  6  one-hot slave select
- `s_we_o`  out  6  per-slave write enable
- `s_addr_o`  out  ADDR_W  shared slave address
- `s_wdata_o`  out  DATA_W  shared slave write data
- `s_rdata_i`  in  6*DATA_W  per-slave read data
- `hold_flag_o`  out  1  core stall request
- `dec_err_o`  out  1  one-cycle pulse after a granted access to an unmapped address

## Operation
- **Winner selection:** evaluated combinationally every cycle among the masters with `m_req_i` high.
  - A starved master beats normal priority. Master k is starved when `wait_cnt[k] == STARVE_LIMIT`, for k = 1..3.
  - Among several starved masters, the lowest index wins.
  - With no starved master, priority is m0 > m1 > m2 > m3.
  - With no request pending there is no winner: all `s_sel_o`/`s_we_o` are 0 and `hold_flag_o` = 0.
- **Wait counters:**
  - m1..m3 each have a 4-bit `wait_cnt`.
  - A counter increments when its master requests and is not the winner, saturating at `STARVE_LIMIT`.
  - It clears to 0 when its master wins or drops its request.
  - m0 has no counter.
- **Address decode:**
  - The slave index is the winner's `addr[31:28]`.
  - Values 0..5 select `s_sel_o[idx]`.
  - `s_addr_o` = {4'h0, addr[27:0]}.
  - `s_we_o[idx]` = winner's `m_we_i`.
  - `s_wdata_o` = winner's `m_wdata_i`.
- **Read return:**
  - The winner's `m_rdata_o` = `s_rdata_i[idx]`.
  - Non-winners get `m_rdata_o` = 0.
  - An unmapped address (idx 6..15) selects no slave and returns 0.
- **Decode errors:** `dec_err_q` is registered to 1 for one cycle after a cycle with a winner and an unmapped idx.
- **Core stall:** `hold_flag_o` = 1 when a winner exists and the winner is not m1. The whole core then stalls, and m0 re-presents its request in following cycles.

## Timing
- **Reset (`rst` low):**
  - `wait_cnt` = 0 and `dec_err_o` = 0, asynchronously.
  - All outputs are forced to 0: `s_sel_o`, `s_we_o`, `s_addr_o`, `s_wdata_o`, `m_rdata_o`, `hold_flag_o`.
- **Transfer latency:** 0 cycles. Path is req → winner → slave select → `s_rdata_i` → `m_rdata_o` within one cycle. A write commits at the slave on the clk edge that ends the winning cycle.
- **Counter latency:** `wait_cnt` updates on the rising `clk` edge. A master losing for `STARVE_LIMIT` consecutive cycles wins in the cycle after.
- **Simultaneous events:**
  - A master that wins has its counter cleared, even if it had reached saturation.
  - A request dropped mid-wait clears the counter; re-request starts from 0.
- **Reset mid-operation:** reset drops any in-flight access with no slave write; counters restart at 0.
- **Wrap-around:** none. Counters saturate at `STARVE_LIMIT`.

## Structure
- Shared package `rib_defs`:
  - `RIB_MASTERS` = 4, `RIB_SLAVES` = 6, `RIB_SEL_MSB` = 31, `RIB_SEL_LSB` = 28
  - master index constants `M_EX` = 0, `M_PC` = 1, `M_JTAG` = 2, `M_UART` = 3
  - `WAIT_CNT_W` = 4
- One sub-module, `rib_prio_pick`: combinational, starvation-aware priority picker. Inputs are req[3:0] and starved[3:1]; outputs are a one-hot grant and a valid flag.
- The top holds the counters, decode, muxing and the `dec_err` register.

## Test plan
- **Reset:** `rst` low with all requests high → all outputs 0. Release → m0 wins, `hold_flag_o` = 1.
- **Priority read:** m1 and m2 request, m1 addr 0x0000_0010, `s_rdata_i[0]` = 0xDEAD_BEEF → `s_sel_o` = 6'b000001, `m_rdata_o[m1]` = 0xDEAD_BEEF, `m_rdata_o[m2]` = 0, `hold_flag_o` = 0.
- **Starvation:** `STARVE_LIMIT` = 8; m1 and m3 request continuously → m1 wins 8 cycles, m3 wins cycle 9 with `hold_flag_o` = 1, then m1 resumes and m3's counter restarts at 0.
- **Write routing:** m0 writes 0x1234_5678 to 0x3000_0004 → `s_sel_o[3]` = 1, `s_we_o` = 6'b001000, `s_addr_o` = 0x0000_0004, `s_wdata_o` = 0x1234_5678.
- **Unmapped address:** m2 reads 0x7000_0000 → `s_sel_o` = 0, `m_rdata_o[m2]` = 0, `dec_err_o` = 1 for exactly the next cycle.
- **Async reset mid-stream:** assert `rst` asynchronously while m3's counter = 5 → counter reads 0 immediately and `s_we_o` = 0 with no clock edge.
